// File: rtl/zero_count_pipe_pkg.sv
// -----------------------------------------------------------------------------
// zero_count_pipe_pkg
// Shared floating-point helper constants used by the zero-count pipeline.
//   MODE_TRAILING : count zeros from bit 0 upward
//   MODE_LEADING  : count zeros from the MSB downward
// -----------------------------------------------------------------------------
package zero_count_pipe_pkg;

    localparam logic MODE_TRAILING = 1'b0;
    localparam logic MODE_LEADING  = 1'b1;

endpackage

// File: rtl/zero_count_pipe_if.sv
// -----------------------------------------------------------------------------
// zero_count_pipe_if
// Input/output valid-ready streams of the zero-count pipeline.
//   in_valid/in_ready/in_data/in_mode     : operand stream (producer -> block)
//   out_valid/out_ready/out_count/
//   out_zero/out_data                     : result stream (block -> consumer)
// Modports: slave = the pipeline, master = the environment driving it.
// -----------------------------------------------------------------------------
interface zero_count_pipe_if #(
    parameter int Width      = 25,
    parameter int CountWidth = $clog2(Width + 1)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [Width-1:0]      in_data;
    logic                  in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [CountWidth-1:0] out_count;
    logic                  out_zero;
    logic [Width-1:0]      out_data;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_count, out_zero, out_data
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_count, out_zero, out_data
    );
endinterface

// File: rtl/zero_count_core.sv
// -----------------------------------------------------------------------------
// zero_count_core
// Combinational zero counter.
//   data  : operand
//   mode  : MODE_TRAILING or MODE_LEADING
//   count : number of zeros below the lowest (trailing) or above the highest
//           (leading) set bit; Width when the operand is all zeros
//   zero  : operand is all zeros
// The leading count reuses the trailing counter on the bit-reversed operand.
// -----------------------------------------------------------------------------
module zero_count_core
    import zero_count_pipe_pkg::*;
#(
    parameter int Width      = 25,
    parameter int CountWidth = $clog2(Width + 1)
) (
    input  logic [Width-1:0]      data,
    input  logic                  mode,
    output logic [CountWidth-1:0] count,
    output logic                  zero
);
    logic [Width-1:0] operand;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        operand = data;
        if (mode == MODE_LEADING) begin
            for (int i = 0; i < Width; i++) begin
                operand[i] = data[Width-1-i];
            end
        end
    end

    // Scan downward so the lowest set bit is the last one to win.
    always_comb begin
        count = CountWidth'(Width);
        for (int i = Width - 1; i >= 0; i--) begin
            if (operand[i]) begin
                count = CountWidth'(i);
            end
        end
    end

    assign zero = (data == '0);

endmodule

// File: rtl/zero_count_pipe.sv
// -----------------------------------------------------------------------------
// zero_count_pipe
// Two-stage valid/ready pipeline that counts leading or trailing zeros of an
// operand and normalizes it by shifting those zeros out.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : operand and result streams (zero_count_pipe_if.slave)
// Stage 1 holds operand, mode, count and zero flag; stage 2 holds the shifted
// operand, count, zero flag and mode. in_ready depends only on state and
// out_ready, never on in_valid.
// -----------------------------------------------------------------------------
module zero_count_pipe
    import zero_count_pipe_pkg::*;
#(
    parameter int Width      = 25,
    parameter int CountWidth = $clog2(Width + 1)
) (
    input  logic               clk,
    input  logic               reset,
    zero_count_pipe_if.slave   bus
);
    logic                  s1_valid, s2_valid;
    logic                  s1_adv, s2_adv;
    logic [Width-1:0]      s1_data, s2_data;
    logic                  s1_mode, s2_mode;
    logic [CountWidth-1:0] s1_count, s2_count;
    logic                  s1_zero, s2_zero;
    logic [CountWidth-1:0] core_count;
    logic                  core_zero;
    logic [Width-1:0]      shifted;

    zero_count_core #(
        .Width      (Width),
        .CountWidth (CountWidth)
    ) u_core (
        .data  (bus.in_data),
        .mode  (bus.in_mode),
        .count (core_count),
        .zero  (core_zero)
    );

    // A stage moves when it is empty or its downstream is taking its contents.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= bus.in_valid;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    // An all-zero operand carries count == Width; force the result to zero
    // rather than relying on oversized-shift behaviour.
    always_comb begin
        shifted = '0;
        if (!s1_zero) begin
            if (s1_mode == MODE_TRAILING) shifted = s1_data >> s1_count;
            else                          shifted = s1_data << s1_count;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: payload is cleared on reset so the result port reads zero while idle after reset.
        if (reset) begin
            s1_data  <= '0;
            s1_mode  <= MODE_TRAILING;
            s1_count <= '0;
            s1_zero  <= 1'b0;
        end else if (s1_adv && bus.in_valid) begin
            s1_data  <= bus.in_data;
            s1_mode  <= bus.in_mode;
            s1_count <= core_count;
            s1_zero  <= core_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_data  <= '0;
            s2_mode  <= MODE_TRAILING;
            s2_count <= '0;
            s2_zero  <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            s2_data  <= shifted;
            s2_mode  <= s1_mode;
            s2_count <= s1_count;
            s2_zero  <= s1_zero;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_count = s2_count;
    assign bus.out_zero  = s2_zero;
    assign bus.out_data  = s2_data;

    // A non-zero normalized result always has its set bit at the edge it was
    // shifted toward.
    a_normalized: assert property (@(posedge clk) disable iff (reset)
        (s2_valid && !s2_zero) |->
            ((s2_mode == MODE_LEADING) ? s2_data[Width-1] : s2_data[0]));

endmodule

// File: tb/tb_zero_count_pipe.sv
// -----------------------------------------------------------------------------
// tb_zero_count_pipe
// Self-checking bench for zero_count_pipe (Width = 25): directed latency,
// zero-operand, backpressure and reset steps, then a randomized stream
// compared against an arithmetic reference model through a result queue.
// -----------------------------------------------------------------------------
module tb_zero_count_pipe;
    import zero_count_pipe_pkg::*;

    localparam int W  = 25;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        int           cnt;
        logic         zero;
        logic [W-1:0] data;
    } result_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    zero_count_pipe_if #(.Width(W)) bus ();

    zero_count_pipe #(.Width(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int      checks = 0;
    int      failures = 0;
    result_t expq[$];
    int      n_sent, n_rcvd;
    logic    ready_seen, delivered;
    logic    have_hold;
    logic [CW-1:0] hold_count;
    logic          hold_zero;
    logic [W-1:0]  hold_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: count from the definition of lowest/highest set bit.
    function automatic result_t ref_model(input logic [W-1:0] d, input logic m);
        result_t r;
        int hi;
        if (d == '0) begin
            r.cnt = W; r.zero = 1'b1; r.data = '0;
        end else if (m == MODE_TRAILING) begin
            r.cnt = 0;
            while (d[r.cnt] == 1'b0) r.cnt++;
            r.zero = 1'b0;
            r.data = d >> r.cnt;
        end else begin
            hi = W - 1;
            while (d[hi] == 1'b0) hi--;
            r.cnt  = W - 1 - hi;
            r.zero = 1'b0;
            r.data = d << r.cnt;
        end
        return r;
    endfunction

    // One clock cycle: drive, observe at the falling edge, then step past the
    // rising edge where the observed handshakes take effect.
    task automatic tick(input logic iv, input logic [W-1:0] d, input logic m, input logic ordy);
        result_t e;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.out_ready = ordy;
        @(negedge clk);
        ready_seen = bus.in_ready;
        delivered  = 1'b0;
        if (have_hold) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_count", 64'(bus.out_count), 64'(hold_count));
            check("hold_zero",  64'(bus.out_zero),  64'(hold_zero));
            check("hold_data",  64'(bus.out_data),  64'(hold_data));
        end
        if (bus.out_valid) check("spurious_out", 64'(expq.size() != 0), 64'd1);
        if (bus.out_valid && ordy && expq.size() != 0) begin
            e = expq.pop_front();
            check("res_count", 64'(bus.out_count), 64'(e.cnt));
            check("res_zero",  64'(bus.out_zero),  64'(e.zero));
            check("res_data",  64'(bus.out_data),  64'(e.data));
            delivered = 1'b1;
            n_rcvd++;
        end
        have_hold  = bus.out_valid && !ordy;
        hold_count = bus.out_count;
        hold_zero  = bus.out_zero;
        hold_data  = bus.out_data;
        if (iv && bus.in_ready) begin
            expq.push_back(ref_model(d, m));
            n_sent++;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge with an operand offered at the same time.
    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = W'(25'h0000100);
        bus.in_mode   = MODE_TRAILING;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        expq.delete();
        have_hold = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        check("rst_out_zero",  64'(bus.out_zero),  64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    endtask

    // Single operand into an empty pipe, checked for exact two-cycle latency.
    task automatic send_and_check(input string tag, input logic [W-1:0] d, input logic m,
                                  input int exp_cnt, input logic exp_zero, input logic [W-1:0] exp_data);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_early_valid"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_count"}, 64'(bus.out_count), 64'(exp_cnt));
        check({tag, "_zero"},  64'(bus.out_zero),  64'(exp_zero));
        check({tag, "_data"},  64'(bus.out_data),  64'(exp_data));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int first_k, last_k, k, cyc, kind, rcvd_before;
        logic [W-1:0] d;

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 1'b0; bus.out_ready = 1'b0;
        n_sent = 0; n_rcvd = 0; have_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Directed values and latency.
        send_and_check("trail_bit3", W'(25'h0000008), MODE_TRAILING, 3, 1'b0, W'(25'h0000001));
        send_and_check("lead_bit17", W'(25'h0020000), MODE_LEADING,  7, 1'b0, W'(25'h1000000));
        send_and_check("trail_zero", W'(0),           MODE_TRAILING, W, 1'b1, W'(0));
        send_and_check("lead_zero",  W'(0),           MODE_LEADING,  W, 1'b1, W'(0));
        send_and_check("lead_msb",   W'(25'h1000001), MODE_LEADING,  0, 1'b0, W'(25'h1000001));
        send_and_check("trail_msb",  W'(25'h1000000), MODE_TRAILING, 24, 1'b0, W'(25'h0000001));

        // Six back-to-back operands with the consumer stalled for four cycles.
        n_sent = 0; n_rcvd = 0; first_k = -1; last_k = -1; k = 0;
        while ((n_rcvd < 6) && (k < 40)) begin
            d = W'($urandom) | W'(1);
            d = d << (k % 7);
            tick(n_sent < 6, d, (k % 2 == 0) ? MODE_LEADING : MODE_TRAILING, k >= 4);
            if (k == 2 || k == 3) begin
                check("stream_in_ready_low", 64'(ready_seen), 64'd0);
                check("stream_two_accepted", 64'(n_sent), 64'd2);
            end
            if (delivered) begin
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            k++;
        end
        check("stream_all_results", 64'(n_rcvd), 64'd6);
        check("stream_no_gap", 64'(last_k - first_k), 64'd5);

        // Reset while both stages are full.
        tick(1'b1, W'(25'h0000400), MODE_TRAILING, 1'b0);
        tick(1'b1, W'(25'h0000010), MODE_LEADING,  1'b0);
        tick(1'b0, W'(0),           MODE_TRAILING, 1'b0);
        check("full_in_ready_low", 64'(ready_seen), 64'd0);
        do_reset();
        rcvd_before = n_rcvd;
        repeat (6) tick(1'b0, W'(0), MODE_TRAILING, 1'b1);
        check("no_stale_after_reset", 64'(n_rcvd), 64'(rcvd_before));

        // Randomized stream with random backpressure.
        n_sent = 0; n_rcvd = 0; cyc = 0;
        while (((n_sent < 10000) || (expq.size() != 0)) && (cyc < 60000)) begin
            kind = $urandom_range(0, 7);
            case (kind)
                0:       d = '0;
                1, 2:    d = W'(1) << $urandom_range(0, W - 1);
                3:       d = W'($urandom) >> $urandom_range(0, W - 1);
                4:       d = W'($urandom) << $urandom_range(0, W - 1);
                default: d = W'($urandom);
            endcase
            tick((n_sent < 10000) && ($urandom_range(0, 3) != 0), d,
                 logic'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
            cyc++;
        end
        check("random_all_accepted", 64'(n_sent), 64'd10000);
        check("random_all_received", 64'(n_rcvd), 64'd10000);
        check("random_drained", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zero_count_pipe.md
ZERO_COUNT_PIPE -- requirements
Module: zero_count_pipe

Interface
REQ-001 SHALL have parameter Width, default 25, meaning operand width in bits (mantissa plus hidden and guard bits); legal range 4..64.
REQ-002 SHALL have parameter CountWidth, default $clog2(Width+1), meaning width of the count output; it is derived, never overridden.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the input operand is presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the operand this cycle.
REQ-007 SHALL have port in_data, input, Width, the operand.
REQ-008 SHALL have port in_mode, input, 1, where 0 means count trailing zeros and 1 means count leading zeros.
REQ-009 SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 SHALL have port out_count, output, CountWidth, the zero count.
REQ-012 SHALL have port out_zero, output, 1, meaning the operand was all zeros.
REQ-013 SHALL have port out_data, output, Width, the normalized operand.

Function
REQ-014 SHALL transfer the input when in_valid and in_ready are both 1 on a rising edge, and the output when out_valid and out_ready are both 1.
REQ-015 SHALL be a 2-stage pipeline; an operand accepted in cycle N is presented with out_valid=1 in cycle N+2 when no stall occurs.
REQ-016 Stage 1 SHALL register in_data, in_mode, the zero count and out_zero; stage 2 SHALL register the shifted data, the count, out_zero and the mode.
REQ-017 Trailing mode: out_count SHALL equal the index of the lowest set bit, and out_data SHALL equal in_data logically shifted right by out_count.
REQ-018 Leading mode: out_count SHALL equal Width-1 minus the index of the highest set bit, and out_data SHALL equal in_data logically shifted left by out_count, truncated to Width.
REQ-019 All-zero operand, either mode: out_count SHALL be Width, out_zero SHALL be 1, and out_data SHALL be 0.
REQ-020 Each stage SHALL advance when it is empty or when the stage downstream of it advances; in_ready SHALL equal NOT stage1_valid OR stage-1 advance, with no combinational path from in_valid.
REQ-021 Backpressure: while out_valid=1 and out_ready=0, out_count, out_zero and out_data SHALL hold stable, and no accepted operand SHALL be lost or duplicated.
REQ-022 Simultaneous accept and drain with both stages full and out_ready=1 SHALL sustain one result per cycle.
REQ-023 Results SHALL leave in acceptance order.
REQ-024 Payload registers SHALL load only on a stage advance; the valid bits SHALL be the only control state.

Reset
REQ-025 With reset=1 at a rising edge, both stage valid bits SHALL clear; after that edge out_valid=0, out_count=0, out_zero=0, out_data=0, and in_ready=1.
REQ-026 Reset mid-operation SHALL discard all in-flight operands, and none SHALL emerge afterwards.
REQ-027 An in_valid asserted in the same cycle as reset SHALL NOT be accepted.

Structure
REQ-028 The mode encodings MODE_TRAILING=0 and MODE_LEADING=1 SHALL live in the shared FP constants header.
REQ-029 Counting SHALL be done in one combinational sub-module, zero_count_core (parameters Width and CountWidth; ports data, mode, count, zero).
REQ-030 The leading count SHALL be computed as the trailing count of the bit-reversed operand inside zero_count_core.

Verification (Width=25)
REQ-031 Trailing, in_data=0x0000008, out_ready=1 -> 2 cycles later out_count=3, out_data=0x0000001, out_zero=0.
REQ-032 Leading, in_data=0x0020000 (bit 17 set) -> out_count=7, out_data=0x1000000.
REQ-033 Both modes, in_data=0 -> out_count=25, out_zero=1, out_data=0.
REQ-034 Stream of 6 back-to-back operands with out_ready held 0 for 4 cycles mid-stream -> in_ready drops after 2 accepts, outputs stay stable, and all 6 results emerge in order with no gap once out_ready=1.
REQ-035 Reset asserted while both stages are full -> next cycle out_valid=0 and in_ready=1, and no stale result appears.
REQ-036 Random 10k operands against a reference model in both modes, with random out_ready -> all results match.
